bcd_display_scan: RTL and testbench

Two-digit multiplexed 7-segment driver that reads the BCD score value (high digit, low digit) produced by the score counter and scans it onto a shared segment bus with per-digit enables. It snapshots the BCD value once per scan frame so the display never tears mid-frame, blanks a leading zero, flags non-BCD codes, and supports a blink mode for game-over indication. It sits between the score counter and the board's 7-segment pins.

---
 rtl/bcd_display_scan.sv | 73 +++++++
 tb/tb_bcd_display_scan.sv | 129 ++++++++++++
 2 files changed

// File: rtl/bcd_display_scan.sv
// bcd_display_scan: two-digit multiplexed 7-segment scanner with per-frame snapshot, leading-zero blanking and blink
module bcd_display_scan #(
  parameter int SCAN_DIV     = 50000,
  parameter int BLINK_FRAMES = 64,
  parameter int COMMON_ANODE = 1
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       en,
  input  logic [3:0] QH,
  input  logic [3:0] QL,
  input  logic       BLINK,
  output logic [6:0] SEG,
  output logic [1:0] AN,
  output logic       FRAME
);
  localparam int PW = $clog2(SCAN_DIV);
  localparam int BW = $clog2(2 * BLINK_FRAMES);
  localparam logic [6:0] SEG_LUT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40
  };
  typedef enum logic {DIG_L, DIG_H} state_t;
  state_t        st_q, st_d;
  logic [PW-1:0] p_q, p_d;
  logic [3:0]    sh_q, sh_d, sl_q, sl_d;
  logic [BW-1:0] b_q, b_d;
  logic [6:0]    seg_q, seg_d;
  logic [1:0]    an_q, an_d;
  logic          frame_q, frame_d;
  logic          tick, fs, vis, lit;
  logic [3:0]    dig;
  always_comb begin
    tick    = p_q == PW'(SCAN_DIV - 1);
    fs      = tick && st_q == DIG_H;
    p_d     = tick ? '0 : p_q + 1'b1;
    st_d    = tick ? (st_q == DIG_L ? DIG_H : DIG_L) : st_q;
    sh_d    = fs ? QH : sh_q;
    sl_d    = fs ? QL : sl_q;
    b_d     = !BLINK ? '0 : !fs ? b_q : b_q == BW'(2 * BLINK_FRAMES - 1) ? '0 : b_q + 1'b1;
    // dropping BLINK shows the display at once, before b has been cleared
    vis     = !BLINK || b_q < BW'(BLINK_FRAMES);
    dig     = st_q == DIG_H ? sh_q : sl_q;
    lit     = en && vis && !(st_q == DIG_H && sh_q == 4'd0);
    seg_d   = lit ? SEG_LUT[dig] : '0;
    an_d    = (lit && p_q != '0) ? (st_q == DIG_H ? 2'b10 : 2'b01) : 2'b00;
    frame_d = fs;
  end
  always_ff @(posedge CLK) begin
    if (RESET) begin
      p_q     <= '0;
      st_q    <= DIG_L;
      sh_q    <= '0;
      sl_q    <= '0;
      b_q     <= '0;
      seg_q   <= '0;
      an_q    <= '0;
      frame_q <= 1'b0;
    end else begin
      p_q     <= p_d;
      st_q    <= st_d;
      sh_q    <= sh_d;
      sl_q    <= sl_d;
      b_q     <= b_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
      frame_q <= frame_d;
    end
  end
  assign SEG   = (COMMON_ANODE != 0) ? ~seg_q : seg_q;
  assign AN    = (COMMON_ANODE != 0) ? ~an_q : an_q;
  assign FRAME = frame_q;
endmodule

// File: tb/tb_bcd_display_scan.sv
// tb_bcd_display_scan: scoreboard bench; stimulus queues per-cycle pin expectations, a negedge monitor pops and compares
module tb_bcd_display_scan;
  localparam logic [6:0] OFF = 7'h7F, S0 = 7'h40, S1 = 7'h79, S2 = 7'h24, S3 = 7'h30;
  localparam logic [6:0] S4 = 7'h19, S7 = 7'h78, SD = 7'h3F;
  logic       CLK = 1'b0, RESET = 1'b1, en = 1'b1, BLINK = 1'b0;
  logic [3:0] QH = 4'd0, QL = 4'd0;
  logic [6:0] SEG;
  logic [1:0] AN;
  logic       FRAME;
  int cyc = 0, n_pass = 0, n_tot = 0, c0 = 0;
  typedef struct {int c; logic [6:0] seg; logic [1:0] an; logic fr; string nm;} exp_t;
  exp_t sb[$];
  exp_t mon_e;
  bcd_display_scan #(.SCAN_DIV(4), .BLINK_FRAMES(2), .COMMON_ANODE(1)) dut (
    .CLK(CLK), .RESET(RESET), .en(en), .QH(QH), .QL(QL), .BLINK(BLINK),
    .SEG(SEG), .AN(AN), .FRAME(FRAME)
  );
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;
  always @(negedge CLK) begin
    while (sb.size() > 0 && sb[0].c <= cyc) begin
      mon_e = sb.pop_front();
      n_tot++;
      if (mon_e.c != cyc)
        $display("FAIL %s: cycle %0d expectation missed (now %0d)", mon_e.nm, mon_e.c, cyc);
      else if ({SEG, AN, FRAME} !== {mon_e.seg, mon_e.an, mon_e.fr})
        $display("FAIL %s: got SEG=%h AN=%b FRAME=%b, want SEG=%h AN=%b FRAME=%b",
                 mon_e.nm, SEG, AN, FRAME, mon_e.seg, mon_e.an, mon_e.fr);
      else n_pass++;
    end
  end
  task automatic push(int c, logic [6:0] s, logic [1:0] a, logic f, string nm);
    exp_t e;
    e.c = c; e.seg = s; e.an = a; e.fr = f; e.nm = nm;
    sb.push_back(e);
  endtask
  // cycles 8f+1..8f+8 after release show the snapshot taken at frame start 8f
  task automatic push_win(int c, int f, logic [6:0] su, logic [6:0] st, bit ton, bit vis,
                          int lo, int hi, string tag);
    for (int i = lo; i <= hi; i++) begin
      logic [6:0] s;
      logic [1:0] a;
      if (i <= 4) begin
        s = vis ? su : OFF;
        a = (vis && i > 1) ? 2'b10 : 2'b11;
      end else begin
        s = (vis && ton) ? st : OFF;
        a = (vis && ton && i > 5) ? 2'b01 : 2'b11;
      end
      push(c + 8 * f + i, s, a, i == 8, $sformatf("%s f%0d i%0d", tag, f, i));
    end
  endtask
  task automatic do_reset(output int c);
    RESET = 1'b1;
    push(cyc + 1, OFF, 2'b11, 1'b0, "reset");
    @(negedge CLK);
    RESET = 1'b0;
    c = cyc;
  endtask
  initial begin
    @(negedge CLK);
    QH = 4'd1; QL = 4'd2;
    do_reset(c0);
    push_win(c0, 0, S0, OFF, 0, 1, 1, 8, "hold12");
    push_win(c0, 1, S2, S1, 1, 1, 1, 8, "hold12");
    push_win(c0, 2, S2, S1, 1, 1, 1, 8, "hold12");
    repeat (24) @(negedge CLK);
    QH = 4'd0; QL = 4'd7;
    do_reset(c0);
    push_win(c0, 0, S0, OFF, 0, 1, 1, 8, "lz07");
    push_win(c0, 1, S7, OFF, 0, 1, 1, 8, "lz07");
    repeat (16) @(negedge CLK);
    QH = 4'd0; QL = 4'd0;
    do_reset(c0);
    push_win(c0, 1, S0, OFF, 0, 1, 1, 8, "zero00");
    repeat (16) @(negedge CLK);
    QH = 4'd0; QL = 4'd3;
    do_reset(c0);
    push_win(c0, 1, S3, OFF, 0, 1, 1, 8, "tear3");
    push_win(c0, 2, S4, OFF, 0, 1, 1, 8, "tear4");
    repeat (11) @(negedge CLK);
    QL = 4'd4;
    repeat (13) @(negedge CLK);
    QH = 4'hA; QL = 4'hF;
    do_reset(c0);
    push_win(c0, 1, SD, SD, 1, 1, 1, 8, "dashAF");
    repeat (16) @(negedge CLK);
    QH = 4'd1; QL = 4'd2; BLINK = 1'b1;
    do_reset(c0);
    push_win(c0, 0, S0, OFF, 0, 1, 1, 8, "blink");
    push_win(c0, 1, S2, S1, 1, 1, 1, 8, "blink");
    push_win(c0, 2, S2, S1, 1, 0, 1, 8, "blink");
    push_win(c0, 3, S2, S1, 1, 0, 1, 8, "blink");
    push_win(c0, 4, S2, S1, 1, 1, 1, 8, "blink");
    push_win(c0, 5, S2, S1, 1, 1, 1, 8, "blink");
    push_win(c0, 6, S2, S1, 1, 0, 1, 2, "blink");
    push_win(c0, 6, S2, S1, 1, 1, 3, 8, "unblink");
    push_win(c0, 7, S2, S1, 1, 1, 1, 8, "unblink");
    repeat (50) @(negedge CLK);
    BLINK = 1'b0;
    repeat (14) @(negedge CLK);
    en = 1'b0;
    do_reset(c0);
    push_win(c0, 0, S0, OFF, 0, 0, 1, 8, "en0");
    push_win(c0, 1, S2, S1, 1, 0, 1, 8, "en0");
    push_win(c0, 2, S2, S1, 1, 1, 1, 8, "en1");
    repeat (16) @(negedge CLK);
    en = 1'b1;
    repeat (8) @(negedge CLK);
    BLINK = 1'b1;
    do_reset(c0);
    push_win(c0, 0, S0, OFF, 0, 1, 1, 8, "prerst");
    push_win(c0, 1, S2, S1, 1, 1, 1, 8, "prerst");
    push_win(c0, 2, S2, S1, 1, 0, 1, 8, "prerst");
    push_win(c0, 3, S2, S1, 1, 0, 1, 5, "prerst");
    repeat (29) @(negedge CLK);
    do_reset(c0);
    push_win(c0, 0, S0, OFF, 0, 1, 1, 8, "postrst");
    push_win(c0, 1, S2, S1, 1, 1, 1, 8, "postrst");
    repeat (18) @(negedge CLK);
    while (sb.size() > 0) begin
      mon_e = sb.pop_front();
      n_tot++;
      $display("FAIL %s: cycle %0d expectation never checked", mon_e.nm, mon_e.c);
    end
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
